decode_stage: RTL and testbench

//  RV32I instruction-decode stage between fetch and execute. Drives the register-file

---
 rtl/decode_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage with ID/EX register, valid/ready handshake and load-use bubble.
// Optional RV32M_DECODE_EN: decode OP funct7=0x01 as MULDIV instead of illegal.
module decode_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [31:0]     if_pc,
    input  logic            flush,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            r1_en,
    output logic            r2_en,
    input  logic [XLEN-1:0] r1_data,
    input  logic [XLEN-1:0] r2_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [31:0]     ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [31:0]     ex_imm,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_we,
    output logic [3:0]      ex_alu_op,
    output logic [3:0]      ex_fmt,
    output logic [2:0]      ex_funct3,
    output logic            ex_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BR     = 7'b1100011;
    localparam logic [6:0] OPC_LD     = 7'b0000011;
    localparam logic [6:0] OPC_ST     = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYS    = 7'b1110011;

    localparam logic [3:0] F_LUI    = 4'd0;
    localparam logic [3:0] F_AUIPC  = 4'd1;
    localparam logic [3:0] F_JAL    = 4'd2;
    localparam logic [3:0] F_JALR   = 4'd3;
    localparam logic [3:0] F_BR     = 4'd4;
    localparam logic [3:0] F_LD     = 4'd5;
    localparam logic [3:0] F_ST     = 4'd6;
    localparam logic [3:0] F_OPIMM  = 4'd7;
    localparam logic [3:0] F_OP     = 4'd8;
    localparam logic [3:0] F_FENCE  = 4'd9;
    localparam logic [3:0] F_SYS    = 4'd10;
`ifdef RV32M_DECODE_EN
    localparam logic [3:0] F_MULDIV = 4'd11;
`endif

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_field;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode   = if_instr[6:0];
    assign funct3   = if_instr[14:12];
    assign funct7   = if_instr[31:25];
    assign rd_field = if_instr[11:7];
    assign rs1      = if_instr[19:15];
    assign rs2      = if_instr[24:20];

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

    logic [3:0]  dec_fmt;
    logic [31:0] dec_imm;
    logic [3:0]  dec_alu_op;
    logic        dec_illegal;
    logic        dec_writes;
    logic        dec_r1;
    logic        dec_r2;
    logic        dec_rd_we;
    logic [4:0]  dec_rd;

    always_comb begin
        dec_fmt     = F_LUI;
        dec_imm     = 32'h0;
        dec_alu_op  = 4'h0;
        dec_illegal = 1'b0;
        dec_writes  = 1'b0;
        dec_r1      = 1'b0;
        dec_r2      = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_fmt    = F_LUI;
                dec_imm    = imm_u;
                dec_writes = 1'b1;
            end
            OPC_AUIPC: begin
                dec_fmt    = F_AUIPC;
                dec_imm    = imm_u;
                dec_writes = 1'b1;
            end
            OPC_JAL: begin
                dec_fmt    = F_JAL;
                dec_imm    = imm_j;
                dec_writes = 1'b1;
            end
            OPC_JALR: begin
                dec_fmt    = F_JALR;
                dec_imm    = imm_i;
                dec_writes = 1'b1;
                dec_r1     = 1'b1;
            end
            OPC_BR: begin
                dec_fmt = F_BR;
                dec_imm = imm_b;
                dec_r1  = 1'b1;
                dec_r2  = 1'b1;
            end
            OPC_LD: begin
                dec_fmt    = F_LD;
                dec_imm    = imm_i;
                dec_writes = 1'b1;
                dec_r1     = 1'b1;
            end
            OPC_ST: begin
                dec_fmt = F_ST;
                dec_imm = imm_s;
                dec_r1  = 1'b1;
                dec_r2  = 1'b1;
            end
            OPC_OPIMM: begin
                dec_fmt    = F_OPIMM;
                dec_imm    = imm_i;
                dec_writes = 1'b1;
                dec_r1     = 1'b1;
                // bit 30 selects SRAI only on right shifts; elsewhere it is immediate data
                dec_alu_op = {(funct3 == 3'b101) & funct7[5], funct3};
                dec_illegal = (funct3 == 3'b001) ? (funct7 != 7'h00) :
                              (funct3 == 3'b101) ? (funct7 != 7'h00 && funct7 != 7'h20) : 1'b0;
            end
            OPC_OP: begin
                dec_fmt    = F_OP;
                dec_writes = 1'b1;
                dec_r1     = 1'b1;
                dec_r2     = 1'b1;
                dec_alu_op = {funct7[5], funct3};
                if (funct7 == 7'h00) begin
                    dec_illegal = 1'b0;
                end else if (funct7 == 7'h20) begin
                    dec_illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
`ifdef RV32M_DECODE_EN
                end else if (funct7 == 7'h01) begin
                    dec_fmt    = F_MULDIV;
                    dec_alu_op = {1'b0, funct3};
`endif
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_FENCE: begin
                dec_fmt = F_FENCE;
                dec_imm = imm_i;
            end
            OPC_SYS: begin
                dec_fmt    = F_SYS;
                dec_imm    = imm_i;
                dec_writes = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_rd_we = dec_writes & !dec_illegal & (rd_field != 5'd0);
    assign dec_rd    = dec_rd_we ? rd_field : 5'd0;
    assign r1_en     = if_valid & dec_r1;
    assign r2_en     = if_valid & dec_r2;

    logic hazard;
    logic advance;

    assign hazard   = ex_valid & (ex_fmt == F_LD) & (ex_rd != 5'd0) &
                      ((r1_en & (rs1 == ex_rd)) | (r2_en & (rs2 == ex_rd)));
    assign advance  = !ex_valid | ex_ready;
    assign if_ready = advance & !hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_pc      <= RESET_PC;
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_imm     <= 32'h0;
            ex_rd      <= 5'd0;
            ex_rd_we   <= 1'b0;
            ex_alu_op  <= 4'h0;
            ex_fmt     <= 4'h0;
            ex_funct3  <= 3'h0;
            ex_illegal <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (advance) begin
            ex_valid <= if_valid & !hazard;
            if (if_valid & !hazard) begin
                ex_pc      <= if_pc;
                ex_rs1_val <= r1_data;
                ex_rs2_val <= r2_data;
                ex_imm     <= dec_imm;
                ex_rd      <= dec_rd;
                ex_rd_we   <= dec_rd_we;
                ex_alu_op  <= dec_alu_op;
                ex_fmt     <= dec_fmt;
                ex_funct3  <= funct3;
                ex_illegal <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage (decode, load-use bubble, stall, flush, reset).
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic [4:0]  rs1, rs2;
    logic        r1_en, r2_en;
    logic [31:0] r1_data, r2_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic [3:0]  ex_alu_op, ex_fmt;
    logic [2:0]  ex_funct3;
    logic        ex_illegal;

    int checks = 0;
    int errors = 0;

    decode_stage #(.XLEN(32), .RESET_PC(32'h0000_0080)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .rs1(rs1), .rs2(rs2), .r1_en(r1_en), .r2_en(r2_en),
        .r1_data(r1_data), .r2_data(r2_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_alu_op(ex_alu_op),
        .ex_fmt(ex_fmt), .ex_funct3(ex_funct3), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0; flush = 1'b0;
        r1_data = 32'h0; r2_data = 32'h0; ex_ready = 1'b1;
        #12 rst = 1'b0;
        #1;
        chk("reset_valid", ex_valid, 0);
        chk("reset_pc", ex_pc, 32'h80);
        chk("reset_if_ready", if_ready, 1);

        // addi x1,x2,5
        if_valid = 1'b1; if_instr = 32'h00510093; if_pc = 32'h100; r1_data = 32'd7; r2_data = 32'd9;
        #1;
        chk("addi_rs1", rs1, 2);
        chk("addi_r1_en", r1_en, 1);
        chk("addi_r2_en", r2_en, 0);
        step();
        chk("addi_valid", ex_valid, 1);
        chk("addi_rd", ex_rd, 1);
        chk("addi_imm", ex_imm, 5);
        chk("addi_rs1_val", ex_rs1_val, 7);
        chk("addi_fmt", ex_fmt, 7);
        chk("addi_rd_we", ex_rd_we, 1);
        chk("addi_pc", ex_pc, 32'h100);
        chk("addi_alu_op", ex_alu_op, 0);
        chk("addi_illegal", ex_illegal, 0);

        // lw x3,0(x1) then add x4,x3,x3
        if_instr = 32'h0000A183; if_pc = 32'h104; r1_data = 32'h1000;
        step();
        chk("lw_fmt", ex_fmt, 5);
        chk("lw_rd", ex_rd, 3);
        chk("lw_funct3", ex_funct3, 2);
        if_instr = 32'h00318233; if_pc = 32'h108; r1_data = 32'h11; r2_data = 32'h22;
        #1;
        chk("hazard_if_ready", if_ready, 0);
        step();
        chk("bubble_valid", ex_valid, 0);
        chk("after_bubble_if_ready", if_ready, 1);
        step();
        chk("add_valid", ex_valid, 1);
        chk("add_rd", ex_rd, 4);
        chk("add_fmt", ex_fmt, 8);
        chk("add_pc", ex_pc, 32'h108);
        chk("add_rs2_val", ex_rs2_val, 32'h22);

        // stall: sw x2,8(x1) waits while execute is busy
        ex_ready = 1'b0; if_instr = 32'h0020A423; if_pc = 32'h10C; r1_data = 32'h300; r2_data = 32'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_if_ready", if_ready, 0);
            step();
            chk("stall_valid", ex_valid, 1);
            chk("stall_rd", ex_rd, 4);
            chk("stall_pc", ex_pc, 32'h108);
        end
        ex_ready = 1'b1;
        #1;
        chk("resume_if_ready", if_ready, 1);
        step();
        chk("sw_fmt", ex_fmt, 6);
        chk("sw_rd", ex_rd, 0);
        chk("sw_rd_we", ex_rd_we, 0);
        chk("sw_imm", ex_imm, 8);
        chk("sw_rs2_val", ex_rs2_val, 32'h55);

        // beq x0,x0,-8
        if_instr = 32'hFE000CE3; if_pc = 32'h110;
        step();
        chk("beq_imm", ex_imm, 32'hFFFF_FFF8);
        chk("beq_fmt", ex_fmt, 4);
        chk("beq_rd_we", ex_rd_we, 0);

        // lui x5,0x12345
        if_instr = 32'h123452B7; if_pc = 32'h114;
        step();
        chk("lui_imm", ex_imm, 32'h12345000);
        chk("lui_rd", ex_rd, 5);
        chk("lui_fmt", ex_fmt, 0);

        // jal x1,8
        if_instr = 32'h008000EF; if_pc = 32'h118;
        step();
        chk("jal_imm", ex_imm, 8);
        chk("jal_fmt", ex_fmt, 2);
        chk("jal_rd", ex_rd, 1);

        // flush squashes addi x6,x0,1
        if_instr = 32'h00100313; if_pc = 32'h11C; flush = 1'b1;
        #1;
        chk("flush_if_ready", if_ready, 1);
        step();
        chk("flush_valid", ex_valid, 0);
        flush = 1'b0; if_valid = 1'b0;
        step();
        chk("flush_still_empty", ex_valid, 0);
        chk("flush_rd_not_seen", ex_rd, 1);

        // mul x5,x1,x2
        if_valid = 1'b1; if_instr = 32'h022082B3; if_pc = 32'h120;
        #1;
        chk("mul_r2_en", r2_en, 1);
        step();
        chk("mul_valid", ex_valid, 1);
`ifdef RV32M_DECODE_EN
        chk("mul_fmt", ex_fmt, 11);
        chk("mul_rd", ex_rd, 5);
        chk("mul_illegal", ex_illegal, 0);
`else
        chk("mul_illegal", ex_illegal, 1);
        chk("mul_rd_we", ex_rd_we, 0);
        chk("mul_rd", ex_rd, 0);
`endif

        if_instr = 32'h00000000; if_pc = 32'h124;
        step();
        chk("zero_valid", ex_valid, 1);
        chk("zero_illegal", ex_illegal, 1);
        chk("zero_rd_we", ex_rd_we, 0);

        // funct7=0x20 with funct3=1 is not a valid OP
        if_instr = 32'h401090B3; if_pc = 32'h128;
        step();
        chk("op_f7_illegal", ex_illegal, 1);

        // async reset while stalled
        if_instr = 32'h00510093; if_pc = 32'h12C;
        step();
        chk("pre_reset_valid", ex_valid, 1);
        ex_ready = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        chk("async_reset_valid", ex_valid, 0);
        chk("async_reset_pc", ex_pc, 32'h80);
        chk("async_reset_rd", ex_rd, 0);
        rst = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        step();
        chk("post_reset_valid", ex_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
